// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor control path.
// Contents: default datapath width, opcode constants, fetch-sequencer state encoding.
// Build option: STEP_MODE_EN adds the single-step wait state (S_STEP).
package proc_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W      = 8;

  // Opcode field IR[7:6]
  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
`ifdef STEP_MODE_EN
    S_ERROR  = 3'd5,
    S_STEP   = 3'd6
`else
    S_ERROR  = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   i_ir          in   DATA_W  instruction register contents
//   o_is_jmp      out  1       JMP opcode
//   o_is_halt     out  1       HALT opcode
//   o_writes_reg  out  1       MOV or ADD (register-file write)
//   o_alu_op      out  1       0 = MOV, 1 = ADD
//   o_imm         out  DATA_W  IR[5:0] sign-extended
module instr_decoder
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_ir,
  output logic              o_is_jmp,
  output logic              o_is_halt,
  output logic              o_writes_reg,
  output logic              o_alu_op,
  output logic [DATA_W-1:0] o_imm
);

  logic [1:0] w_op;

  assign w_op         = i_ir[7:6];
  assign o_is_jmp     = (w_op == OP_JMP);
  assign o_is_halt    = (w_op == OP_HALT);
  assign o_writes_reg = (w_op == OP_MOV) || (w_op == OP_ADD);
  assign o_alu_op     = (w_op == OP_ADD);
  assign o_imm        = {{(DATA_W-6){i_ir[5]}}, i_ir[5:0]};

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the 8-bit processor.
// Owns the instruction register, the fetch timeout counter and the retired count.
// Ports:
//   Clk, Reset_n   clock, asynchronous active-low reset
//   Start          leave IDLE (ignored elsewhere)
//   Step           (STEP_MODE_EN only) release the post-EXEC wait
//   Imem_Req/Ack/Data  instruction memory handshake
//   Instr, Imm_Data, AluOp   IR and its decoded fields
//   PC_En, PCSrc, RegWrite   one-cycle strobes in EXEC
//   Instr_Count    retired MOV/ADD/JMP count (wraps)
//   Halted, Error  sticky terminal flags
// Build option: define STEP_MODE_EN for single-step operation.
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
`ifdef STEP_MODE_EN
  input  logic              Step,
`endif
  output logic              Imem_Req,
  input  logic              Imem_Ack,
  input  logic [DATA_W-1:0] Imem_Data,
  output logic [DATA_W-1:0] Instr,
  output logic              PC_En,
  output logic              PCSrc,
  output logic [DATA_W-1:0] Imm_Data,
  output logic              RegWrite,
  output logic              AluOp,
  output logic [CNT_W-1:0]  Instr_Count,
  output logic              Halted,
  output logic              Error
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_ir;
  logic [CNT_W-1:0]    r_tmo;
  logic [CNT_W-1:0]    r_instr_count;
  logic                r_imem_req;
  logic                r_pc_en;
  logic                r_pc_src;
  logic                r_reg_write;
  logic                r_halted;
  logic                r_error;

  logic                w_is_jmp;
  logic                w_is_halt;
  logic                w_writes_reg;
  logic                w_alu_op;
  logic [DATA_W-1:0]   w_imm;

  instr_decoder #(.DATA_W(DATA_W)) u_dec (
    .i_ir         (r_ir),
    .o_is_jmp     (w_is_jmp),
    .o_is_halt    (w_is_halt),
    .o_writes_reg (w_writes_reg),
    .o_alu_op     (w_alu_op),
    .o_imm        (w_imm)
  );

  // Outputs are registered alongside the state so they line up with the state they belong to.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= S_IDLE;
      r_ir          <= '0;
      r_tmo         <= '0;
      r_instr_count <= '0;
      r_imem_req    <= 1'b0;
      r_pc_en       <= 1'b0;
      r_pc_src      <= 1'b0;
      r_reg_write   <= 1'b0;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_pc_en     <= 1'b0;
      r_pc_src    <= 1'b0;
      r_reg_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          // An ack arriving with r_tmo == TIMEOUT (after TIMEOUT wait cycles) is still taken.
          if (Imem_Ack) begin
            r_ir       <= Imem_Data;
            r_tmo      <= '0;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end else if (r_tmo == CNT_W'(TIMEOUT)) begin
            r_tmo      <= '0;
            r_imem_req <= 1'b0;
            r_error    <= 1'b1;
            r_state    <= S_ERROR;
          end else begin
            r_tmo <= r_tmo + CNT_W'(1);
          end
        end
        S_DECODE: begin
          // Strobes are loaded here so they are visible exactly while state == EXEC.
          r_state <= S_EXEC;
          if (!w_is_halt) begin
            r_pc_en       <= 1'b1;
            r_pc_src      <= w_is_jmp;
            r_reg_write   <= w_writes_reg;
            r_instr_count <= r_instr_count + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
`ifdef STEP_MODE_EN
            r_state    <= S_STEP;
`else
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
`endif
          end
        end
`ifdef STEP_MODE_EN
        S_STEP: begin
          if (Step) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
`endif
        S_HALT, S_ERROR: begin
          r_state <= r_state;
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign Imem_Req    = r_imem_req;
  assign Instr       = r_ir;
  assign PC_En       = r_pc_en;
  assign PCSrc       = r_pc_src;
  assign RegWrite    = r_reg_write;
  assign Instr_Count = r_instr_count;
  assign Halted      = r_halted;
  assign Error       = r_error;
  // Decoded fields settle from the IR register during DECODE.
  assign Imm_Data    = w_imm;
  assign AluOp       = w_alu_op;

endmodule
